pc_gen: RTL and testbench

Parametrised program-counter generator for the pipeline fetch stage, replacing the fixed 32-bit PC register. It keeps the single prioritised update path (flush overrides stall, stall holds) and adds a reset vector, a configurable increment, a top-priority trap redirect, and a small return-address stack (RAS). The RAS lets predicted returns redirect fetch without waiting for branch resolution.

---
 rtl/pc_gen.sv | 60 ++++++
 tb/tb_pc_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with trap/flush redirect, stall hold and return-address stack
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int INC = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_write,
  input  logic                         icache_stall,
  input  logic                         dcache_stall,
  input  logic                         trap_valid,
  input  logic [XLEN-1:0]              trap_target,
  input  logic                         flush,
  input  logic [XLEN-1:0]              flush_target,
  input  logic                         call_push,
  input  logic                         ret_pop,
  output logic [XLEN-1:0]              pc_out,
  output logic [XLEN-1:0]              pc_seq,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);
  localparam int TW = $clog2(RAS_DEPTH);
  localparam int CW = TW + 1;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [TW-1:0] tp, tp_nxt, wr_idx;
  logic [CW-1:0] cnt_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic stall, ras_ok, pop_hit, push, full;
  assign pc_seq  = pc_out + XLEN'(INC);
  assign stall   = !pc_write | icache_stall | dcache_stall;
  assign ras_ok  = !trap_valid & !flush & !stall;
  assign pop_hit = ras_ok & ret_pop & (ras_count != '0);
  assign push    = ras_ok & call_push;
  assign full    = ras_count == CW'(RAS_DEPTH);
  // Prioritised next PC and RAS pointer/count; a push paired with a live pop rewrites the top in place
  always_comb begin
    pc_nxt  = trap_valid ? trap_target : flush ? flush_target : stall ? pc_out : pop_hit ? ras[tp] : pc_seq;
    tp_nxt  = trap_valid ? '0 : (push && !pop_hit) ? tp + TW'(1) : (pop_hit && !push) ? tp - TW'(1) : tp;
    cnt_nxt = trap_valid ? '0 : (push && !pop_hit && !full) ? ras_count + CW'(1) :
              (pop_hit && !push) ? ras_count - CW'(1) : ras_count;
    wr_idx  = pop_hit ? tp : tp + TW'(1);
  end
  // PC and RAS bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out    <= RESET_VECTOR;
      tp        <= '0;
      ras_count <= '0;
    end else begin
      pc_out    <= pc_nxt;
      tp        <= tp_nxt;
      ras_count <= cnt_nxt;
    end
  end
  // RAS storage; contents are meaningless until pushed so it carries no reset
  always_ff @(posedge clk) begin
    if (push) ras[wr_idx] <= pc_seq;
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: vector table, hand sequences and randomized model check for pc_gen
module tb_pc_gen;
  logic clk, rst_n, pc_write, icache_stall, dcache_stall, trap_valid, flush, call_push, ret_pop;
  logic [31:0] trap_target, flush_target, pc_out, pc_seq;
  logic [2:0] ras_count;
  int checks = 0, errors = 0;

  typedef struct {
    logic pw, ic, dc, tr;
    logic [31:0] tt;
    logic fl;
    logic [31:0] ft;
    logic pu, po;
    logic [31:0] epc;
    int ecnt;
  } vec_t;

  vec_t vecs[$];

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .INC(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .icache_stall(icache_stall),
    .dcache_stall(dcache_stall), .trap_valid(trap_valid), .trap_target(trap_target),
    .flush(flush), .flush_target(flush_target), .call_push(call_push), .ret_pop(ret_pop),
    .pc_out(pc_out), .pc_seq(pc_seq), .ras_count(ras_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pw, ic, dc, tr, input logic [31:0] tt, input logic fl,
                              input logic [31:0] ft, input logic pu, po, input logic [31:0] epc, input int ecnt);
    vec_t v;
    v.pw = pw; v.ic = ic; v.dc = dc; v.tr = tr; v.tt = tt; v.fl = fl; v.ft = ft;
    v.pu = pu; v.po = po; v.epc = epc; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic vec_t run(input logic [31:0] epc, input int ecnt);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, epc, ecnt);
  endfunction
  function automatic vec_t fl_to(input logic [31:0] t, input int ecnt);
    return mk(1, 0, 0, 0, 0, 1, t, 0, 0, t, ecnt);
  endfunction
  function automatic vec_t psh(input logic [31:0] epc, input int ecnt);
    return mk(1, 0, 0, 0, 0, 0, 0, 1, 0, epc, ecnt);
  endfunction
  function automatic vec_t pop(input logic [31:0] epc, input int ecnt);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 1, epc, ecnt);
  endfunction

  task automatic drive_idle();
    pc_write = 1; icache_stall = 0; dcache_stall = 0; trap_valid = 0; trap_target = 0;
    flush = 0; flush_target = 0; call_push = 0; ret_pop = 0;
  endtask

  task automatic apply(input vec_t v, input string name);
    pc_write = v.pw; icache_stall = v.ic; dcache_stall = v.dc; trap_valid = v.tr;
    trap_target = v.tt; flush = v.fl; flush_target = v.ft; call_push = v.pu; ret_pop = v.po;
    @(posedge clk);
    #1;
    chk({name, " pc"}, pc_out, v.epc);
    chk({name, " cnt"}, 32'(ras_count), 32'(v.ecnt));
    chk({name, " seq"}, pc_seq, v.epc + 32'd4);
  endtask

  // reference model: pc as a number, RAS as a bounded stack of return addresses
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];

  task automatic model_step(input logic pw, ic, dc, tr, input logic [31:0] tt, input logic fl,
                            input logic [31:0] ft, input logic pu, po);
    logic [31:0] nseq;
    nseq = m_pc + 32'd4;
    if (tr) begin
      m_pc = tt;
      m_stack.delete();
    end else if (fl) m_pc = ft;
    else if (!pw || ic || dc) m_pc = m_pc;
    else if (po && m_stack.size() > 0) begin
      m_pc = m_stack[$];
      if (pu) m_stack[m_stack.size()-1] = nseq;
      else void'(m_stack.pop_back());
    end else begin
      m_pc = nseq;
      if (pu) begin
        m_stack.push_back(nseq);
        if (m_stack.size() > 4) void'(m_stack.pop_front());
      end
    end
  endtask

  initial begin
    drive_idle();
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    chk("reset pc", pc_out, 32'h100);
    chk("reset cnt", 32'(ras_count), 0);
    @(negedge clk) rst_n = 1;
    apply(run(32'h104, 0), "free1");
    apply(run(32'h108, 0), "free2");
    apply(run(32'h10C, 0), "free3");

    vecs.push_back(fl_to(32'h200, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 32'h400, 0, 0, 32'h400, 0));
    vecs.push_back(fl_to(32'h500, 0));
    vecs.push_back(fl_to(32'h600, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h600, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h600, 0));
    vecs.push_back(psh(32'h604, 1));
    vecs.push_back(psh(32'h608, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h608, 2));
    vecs.push_back(mk(1, 0, 0, 1, 32'h80, 1, 32'h400, 1, 0, 32'h80, 0));
    vecs.push_back(fl_to(32'h10, 0));
    vecs.push_back(psh(32'h14, 1));
    vecs.push_back(run(32'h18, 1));
    vecs.push_back(run(32'h1C, 1));
    vecs.push_back(run(32'h20, 1));
    vecs.push_back(pop(32'h14, 0));
    vecs.push_back(pop(32'h18, 0));
    vecs.push_back(psh(32'h1C, 1));
    vecs.push_back(psh(32'h20, 2));
    vecs.push_back(psh(32'h24, 3));
    vecs.push_back(psh(32'h28, 4));
    vecs.push_back(psh(32'h2C, 4));
    vecs.push_back(pop(32'h2C, 3));
    vecs.push_back(pop(32'h28, 2));
    vecs.push_back(pop(32'h24, 1));
    vecs.push_back(pop(32'h20, 0));
    vecs.push_back(pop(32'h24, 0));
    vecs.push_back(fl_to(32'hFFFFFFFC, 0));
    vecs.push_back(run(32'h0, 0));
    vecs.push_back(fl_to(32'h4C, 0));
    vecs.push_back(psh(32'h50, 1));
    vecs.push_back(fl_to(32'h30, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h50, 1));
    vecs.push_back(pop(32'h34, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h38, 1));
    vecs.push_back(pop(32'h38, 0));
    vecs.push_back(psh(32'h3C, 1));
    vecs.push_back(psh(32'h40, 2));
    vecs.push_back(mk(1, 0, 0, 1, 32'h80, 1, 32'h400, 0, 0, 32'h80, 0));
    vecs.push_back(pop(32'h84, 0));
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    apply(psh(32'h88, 1), "full1");
    apply(psh(32'h8C, 2), "full2");
    apply(psh(32'h90, 3), "full3");
    apply(psh(32'h94, 4), "full4");
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h94, 4), "stall_full");
    icache_stall = 1;
    #2 rst_n = 0;
    #1;
    chk("midreset pc", pc_out, 32'h100);
    chk("midreset cnt", 32'(ras_count), 0);
    @(negedge clk) rst_n = 1;
    apply(pop(32'h104, 0), "after_reset");

    m_pc = 32'h104;
    m_stack.delete();
    for (int n = 0; n < 1500; n++) begin
      logic pw, ic, dc, tr, fl, pu, po;
      logic [31:0] tt, ft;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        #1;
        m_pc = 32'h100;
        m_stack.delete();
        chk("rnd reset pc", pc_out, m_pc);
        chk("rnd reset cnt", 32'(ras_count), 0);
        #1 rst_n = 1;
      end
      pw = $urandom_range(0, 9) != 0;
      ic = $urandom_range(0, 9) == 0;
      dc = $urandom_range(0, 19) == 0;
      tr = $urandom_range(0, 39) == 0;
      fl = $urandom_range(0, 9) == 0;
      pu = $urandom_range(0, 9) < 3;
      po = $urandom_range(0, 9) < 3;
      tt = $urandom;
      ft = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
      pc_write = pw; icache_stall = ic; dcache_stall = dc; trap_valid = tr; trap_target = tt;
      flush = fl; flush_target = ft; call_push = pu; ret_pop = po;
      model_step(pw, ic, dc, tr, tt, fl, ft, pu, po);
      @(posedge clk);
      #1;
      chk("rnd pc", pc_out, m_pc);
      chk("rnd cnt", 32'(ras_count), 32'(m_stack.size()));
      chk("rnd seq", pc_seq, m_pc + 32'd4);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
